// File: rtl/text_buf_writer.sv
// Text buffer writer: turns a stream of ASCII codes into character-RAM writes
// and tracks a (col,row) cursor. Handles CR, LF, BS and FF (clear screen).
// The buffer is blanked after every reset and every FF.
module text_buf_writer #(
  parameter int          COLS       = 16,
  parameter int          ROWS       = 8,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  localparam int         COL_W      = $clog2(COLS),
  localparam int         ROW_W      = $clog2(ROWS),
  localparam int         AW         = COL_W + ROW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [7:0]       wr_data,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy
);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [7:0]    char_q;
  logic          accept;
  logic          clr_last;
  logic          in_print;
  logic          q_print;

  // Reset is folded into the handshake flags so they are defined from time 0.
  assign char_ready = (state == IDLE) && !rst;
  assign busy       = (state == CLEAR) || rst;
  assign accept     = char_valid && char_ready;
  assign clr_last   = (clr_cnt == {AW{1'b1}});
  assign in_print   = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign q_print    = (char_q  >= 8'h20) && (char_q  <= 8'h7E);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next-state: clear sweep, wait for a character, apply it.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = IDLE;
      IDLE:    if (accept) state_nxt = WRITE;
      WRITE:   state_nxt = (char_q == C_FF) ? CLEAR : IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Datapath: the RAM write is decided at acceptance so the strobe lines up
  // with the WRITE cycle; the cursor moves at the end of WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clr_cnt    <= '0;
      char_q     <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_cnt;
          wr_data <= BLANK_CHAR;
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_last) begin
            cursor_col <= '0;
            cursor_row <= '0;
          end
        end
        IDLE: begin
          if (accept) begin
            char_q <= char_in;
            if (in_print) begin
              wr_en   <= 1'b1;
              wr_addr <= {cursor_row, cursor_col};
              wr_data <= char_in;
            end else if (char_in == C_BS && cursor_col != '0) begin
              wr_en   <= 1'b1;
              wr_addr <= {cursor_row, cursor_col - COL_W'(1)};
              wr_data <= BLANK_CHAR;
            end
          end
        end
        WRITE: begin
          if (q_print) begin
            cursor_col <= cursor_col + COL_W'(1);
            if (cursor_col == {COL_W{1'b1}}) cursor_row <= cursor_row + ROW_W'(1);
          end else if (char_q == C_CR) begin
            cursor_col <= '0;
          end else if (char_q == C_LF) begin
            cursor_col <= '0;
            cursor_row <= cursor_row + ROW_W'(1);
          end else if (char_q == C_BS) begin
            if (cursor_col != '0) cursor_col <= cursor_col - COL_W'(1);
          end else if (char_q == C_FF) begin
            clr_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buf_writer.sv
// Bench for text_buf_writer: directed scenarios plus random character stream,
// checked against a screen/cursor model written in plain arithmetic.
module tb_text_buf_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, wr_en, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] cursor_col;
  logic [2:0] cursor_row;

  int n_cmp = 0;
  int n_fail = 0;
  int wq[$];
  int exp_q[$];
  int mcol = 0;
  int mrow = 0;

  always #5 clk = ~clk;

  text_buf_writer dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Record every RAM write; the source must never see ready while clearing.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back(int'({wr_addr, wr_data}));
    if (busy === 1'b1) chk("ready_while_busy", char_ready, 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (char_ready !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("ready_wait", char_ready, 1);
  endtask

  task automatic push_blank_screen();
    for (int a = 0; a < 128; a++) exp_q.push_back((a << 8) | 8'h20);
  endtask

  // Screen model: plain cursor arithmetic on a 16x8 grid.
  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back(((mrow * 16 + mcol) << 8) | int'(c));
      mcol++;
      if (mcol == 16) begin
        mcol = 0;
        mrow = (mrow + 1) % 8;
      end
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % 8;
    end else if (c == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        exp_q.push_back(((mrow * 16 + mcol) << 8) | 8'h20);
      end
    end else if (c == 8'h0C) begin
      push_blank_screen();
      mcol = 0;
      mrow = 0;
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_count"}, wq.size(), exp_q.size());
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, wq[i], exp_q[i]);
    wq.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_col"}, cursor_col, mcol);
    chk({tag, "_row"}, cursor_row, mrow);
  endtask

  // Hand one character over and check the one-cycle ready gap.
  task automatic send(input logic [7:0] c);
    wait_ready(300);
    char_in = c;
    char_valid = 1'b1;
    @(posedge clk);
    tick();
    char_valid = 1'b0;
    char_in = 8'($urandom);
    chk("ready_in_write", char_ready, 0);
    tick();
    chk("ready_after_write", char_ready, (c != 8'h0C));
    chk("busy_after_write", busy, (c == 8'h0C));
  endtask

  task automatic finish_clear();
    wait_ready(300);
    chk("busy_done", busy, 0);
  endtask

  task automatic do_char(input logic [7:0] c);
    send(c);
    model_char(c);
    if (c == 8'h0C) finish_clear();
    check_writes("char");
    check_cursor("char");
  endtask

  initial begin
    logic [7:0] others[8] = '{8'h00, 8'h07, 8'h1B, 8'h1F, 8'h7F, 8'h80, 8'hC3, 8'hFF};
    logic [7:0] c;
    int r, n;

    // Reset state.
    tick();
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    check_cursor("rst");

    // Power-up clear.
    rst = 1'b0;
    push_blank_screen();
    finish_clear();
    check_writes("init_clear");
    check_cursor("init_clear");

    // "A" then "B".
    do_char(8'h41);
    do_char(8'h42);
    chk("ab_col", cursor_col, 2);
    chk("ab_row", cursor_row, 0);

    // Row/column wrap.
    do_char(8'h0C);
    for (int i = 0; i < 7; i++) do_char(8'h0A);
    for (int i = 0; i < 16; i++) do_char(8'h61 + 8'(i));
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 0);
    do_char(8'h0A);
    chk("lf_row", cursor_row, 1);
    for (int i = 0; i < 6; i++) do_char(8'h0A);
    chk("row7", cursor_row, 7);
    do_char(8'h0A);
    chk("lf_wrap_row", cursor_row, 0);

    // Backspace at col 3 and at col 0.
    for (int i = 0; i < 3; i++) do_char(8'h30 + 8'(i));
    send(8'h08);
    chk("bs_count", wq.size(), 1);
    if (wq.size() > 0) chk("bs_write", wq[0], (2 << 8) | 8'h20);
    chk("bs_col", cursor_col, 2);
    model_char(8'h08);
    check_writes("bs");
    do_char(8'h0D);
    do_char(8'h08);
    chk("bs0_col", cursor_col, 0);

    // Form feed at cursor (5,4) with valid held through the clear.
    for (int i = 0; i < 4; i++) do_char(8'h0A);
    for (int i = 0; i < 5; i++) do_char(8'h4B);
    send(8'h0C);
    char_in = 8'h5A;
    char_valid = 1'b1;
    model_char(8'h0C);
    finish_clear();
    check_writes("ff_clear");
    check_cursor("ff_clear");
    do_char(8'h5A);

    // Random character stream.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      c = 8'($urandom_range(32, 126));
      else if (r < 70) c = 8'h0D;
      else if (r < 80) c = 8'h0A;
      else if (r < 90) c = 8'h08;
      else if (r < 98) c = others[$urandom_range(0, 7)];
      else             c = 8'h0C;
      do_char(c);
    end

    // Reset in the middle of a clear.
    send(8'h0C);
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr === 7'd60) && n < 300) begin
      tick();
      n++;
    end
    chk("saw_addr60", wr_addr, 60);
    rst = 1'b1;
    wq.delete();
    exp_q.delete();
    @(posedge clk);
    tick();
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_ready", char_ready, 0);
    tick();
    chk("midrst_wr_en2", wr_en, 0);
    rst = 1'b0;
    mcol = 0;
    mrow = 0;
    push_blank_screen();
    finish_clear();
    if (wq.size() > 0) chk("post_rst_first_addr", wq[0] >> 8, 0);
    check_writes("post_rst_clear");
    check_cursor("post_rst_clear");

    // Unlisted control and high codes are swallowed.
    do_char(8'h41);
    do_char(8'h07);
    do_char(8'hC3);
    chk("ignore_col", cursor_col, 1);
    chk("ignore_row", cursor_row, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
